// File: rtl/dlx_pkg.sv
// Shared DLX execute-stage types: opselect encodings, issue FSM states, scoreboard entry.
package dlx_pkg;

  localparam logic [2:0] OP_SHIFT_REG   = 3'b000;
  localparam logic [2:0] OP_ARITH_LOGIC = 3'b001;
  localparam logic [2:0] OP_MEM_WRITE   = 3'b100;
  localparam logic [2:0] OP_MEM_READ    = 3'b101;

  typedef enum logic [0:0] {
    IDLE,
    MEM_WAIT
  } ex_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  // Only register-writing ops with a real destination can cause a RAW hazard.
  function automatic logic writes_rd(input logic [2:0] opsel, input logic [4:0] rd);
    return ((opsel == OP_SHIFT_REG) || (opsel == OP_ARITH_LOGIC) || (opsel == OP_MEM_READ))
           && (rd != 5'd0);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] val);
    return {{16{val[15]}}, val};
  endfunction

endpackage

// File: rtl/ex_scoreboard.sv
// Two-deep destination scoreboard for instructions in flight in execute, plus the
// combinational RAW hazard compare against the sources of the decode-stage instruction.
module ex_scoreboard
  import dlx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [4:0] push_rd,
  input  logic       dec_valid,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  output logic       hazard
);

  sb_entry_t sb0_q, sb1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sb0_q <= '0;
      sb1_q <= '0;
    end else begin
      sb0_q <= '{valid: push_valid, rd: push_rd};
      sb1_q <= sb0_q;
    end
  end

  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit = (dec_rs1 != 5'd0) &&
              ((sb0_q.valid && (sb0_q.rd == dec_rs1)) || (sb1_q.valid && (sb1_q.rd == dec_rs1)));
    rs2_hit = (dec_rs2 != 5'd0) &&
              ((sb0_q.valid && (sb0_q.rd == dec_rs2)) || (sb1_q.valid && (sb1_q.rd == dec_rs2)));
    hazard  = dec_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// DLX execute issue controller: valid/ready intake, memory-read sequencing with timeout,
// optional RAW interlock (enabled by defining EX_HAZARD_INTERLOCK_EN).
module ex_issue_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [6:0]  dec_control,
  input  logic [15:0] dec_imm16,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  output logic        enable_ex,
  output logic [6:0]  control_out,
  output logic [31:0] imm_out,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  output logic        mem_err,
  output logic [15:0] stall_count
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  ex_state_t   state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        enable_q, enable_d;
  logic [6:0]  control_q, control_d;
  logic [31:0] imm_q, imm_d;
  logic [6:0]  pend_ctrl_q, pend_ctrl_d;
  logic [31:0] pend_imm_q, pend_imm_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        err_q, err_d;
  logic        sb_push_valid;
  logic [4:0]  sb_push_rd;
  logic        hazard;
  logic        accept, is_mem_rd;

  assign dec_ready   = reset && (state_q == IDLE) && !hazard;
  assign accept      = dec_valid && dec_ready;
  assign is_mem_rd   = (dec_control[2:0] == OP_MEM_READ) && dec_control[3];
  assign enable_ex   = enable_q;
  assign control_out = control_q;
  assign imm_out     = imm_q;
  assign mem_rd_req  = (state_q == MEM_WAIT);
  assign mem_err     = err_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    enable_d      = 1'b0;
    control_d     = control_q;
    imm_d         = imm_q;
    pend_ctrl_d   = pend_ctrl_q;
    pend_imm_d    = pend_imm_q;
    pend_rd_d     = pend_rd_q;
    err_d         = 1'b0;
    sb_push_valid = 1'b0;
    sb_push_rd    = dec_rd;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem_rd) begin
            pend_ctrl_d = dec_control;
            pend_imm_d  = sext16(dec_imm16);
            pend_rd_d   = dec_rd;
            wait_cnt_d  = 8'd0;
            state_d     = MEM_WAIT;
          end else begin
            enable_d      = 1'b1;
            control_d     = dec_control;
            imm_d         = sext16(dec_imm16);
            sb_push_valid = writes_rd(dec_control[2:0], dec_rd);
          end
        end
      end
      MEM_WAIT: begin
        // Ack beats a coincident timeout.
        if (mem_rd_ack) begin
          enable_d      = 1'b1;
          control_d     = pend_ctrl_q;
          imm_d         = pend_imm_q;
          sb_push_valid = (pend_rd_q != 5'd0);
          sb_push_rd    = pend_rd_q;
          state_d       = IDLE;
        end else if (wait_cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      enable_q    <= 1'b0;
      control_q   <= '0;
      imm_q       <= '0;
      pend_ctrl_q <= '0;
      pend_imm_q  <= '0;
      pend_rd_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      enable_q    <= enable_d;
      control_q   <= control_d;
      imm_q       <= imm_d;
      pend_ctrl_q <= pend_ctrl_d;
      pend_imm_q  <= pend_imm_d;
      pend_rd_q   <= pend_rd_d;
      err_q       <= err_d;
    end
  end

`ifdef EX_HAZARD_INTERLOCK_EN
  logic [15:0] stall_q;

  ex_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .push_valid (sb_push_valid),
    .push_rd    (sb_push_rd),
    .dec_valid  (dec_valid),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .hazard     (hazard)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  logic unused_sb;

  assign hazard      = 1'b0;
  assign stall_count = '0;
  assign unused_sb   = ^{sb_push_valid, sb_push_rd, dec_rs1, dec_rs2};
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed, table-driven bench for ex_issue_ctrl; expectations follow EX_HAZARD_INTERLOCK_EN.
module tb_ex_issue_ctrl;

`ifdef EX_HAZARD_INTERLOCK_EN
  localparam bit ILK = 1'b1;
`else
  localparam bit ILK = 1'b0;
`endif
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, dec_valid, dec_ready, enable_ex, mem_rd_req, mem_rd_ack, mem_err;
  logic [6:0]  dec_control, control_out;
  logic [15:0] dec_imm16, stall_count;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] imm_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_control (dec_control),
    .dec_imm16   (dec_imm16),
    .dec_rd      (dec_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .enable_ex   (enable_ex),
    .control_out (control_out),
    .imm_out     (imm_out),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_ack  (mem_rd_ack),
    .mem_err     (mem_err),
    .stall_count (stall_count)
  );

  typedef struct {
    logic        rst_n, valid;
    logic [6:0]  ctrl;
    logic [15:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        ack;
    logic        x_ready, x_en;
    logic [6:0]  x_ctrl;
    logic [31:0] x_imm;
    logic        x_req, x_err;
    logic [15:0] x_stall;
    logic        x_data;
  } vec_t;

  function automatic vec_t vec(input logic rst_n, valid, input logic [6:0] ctrl,
                               input logic [15:0] imm, input logic [4:0] rd, rs1, rs2,
                               input logic ack, input logic x_ready, x_en,
                               input logic [6:0] x_ctrl, input logic [31:0] x_imm,
                               input logic x_req, x_err, input logic [15:0] x_stall,
                               input logic x_data);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.ctrl = ctrl; v.imm = imm;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ack = ack;
    v.x_ready = x_ready; v.x_en = x_en; v.x_ctrl = x_ctrl; v.x_imm = x_imm;
    v.x_req = x_req; v.x_err = x_err; v.x_stall = x_stall; v.x_data = x_data;
    return v;
  endfunction

  function automatic logic [15:0] st(input int n);
    return ILK ? 16'(n) : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; dec_ready sampled before the edge, registered outputs after.
  task automatic run_vec(input vec_t v, input string tag);
    reset = v.rst_n; dec_valid = v.valid; dec_control = v.ctrl; dec_imm16 = v.imm;
    dec_rd = v.rd; dec_rs1 = v.rs1; dec_rs2 = v.rs2; mem_rd_ack = v.ack;
    #1;
    chk({tag, ".dec_ready"}, {31'd0, dec_ready}, {31'd0, v.x_ready});
    @(posedge clk);
    #1;
    chk({tag, ".enable_ex"}, {31'd0, enable_ex}, {31'd0, v.x_en});
    chk({tag, ".mem_rd_req"}, {31'd0, mem_rd_req}, {31'd0, v.x_req});
    chk({tag, ".mem_err"}, {31'd0, mem_err}, {31'd0, v.x_err});
    chk({tag, ".stall_count"}, {16'd0, stall_count}, {16'd0, v.x_stall});
    if (v.x_data) begin
      chk({tag, ".control_out"}, {25'd0, control_out}, {25'd0, v.x_ctrl});
      chk({tag, ".imm_out"}, imm_out, v.x_imm);
    end
  endtask

  vec_t main_tbl[14];
  vec_t haz_tbl[15];
  vec_t idle_v;

  initial begin
    // reset, back-to-back issue, held outputs, memory read acked on its 4th request cycle
    main_tbl[0]  = vec(0, 0, 7'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 0, 0, 0, 1);
    main_tbl[1]  = vec(0, 0, 7'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 0, 0, 0, 1);
    main_tbl[2]  = vec(1, 1, 7'h09, 16'hFFFE, 5, 1, 0, 0, 1, 1, 7'h09, 32'hFFFFFFFE, 0, 0, 0, 1);
    main_tbl[3]  = vec(1, 1, 7'h19, 16'hFFFE, 6, 2, 0, 0, 1, 1, 7'h19, 32'hFFFFFFFE, 0, 0, 0, 1);
    main_tbl[4]  = vec(1, 1, 7'h29, 16'hFFFE, 7, 3, 0, 0, 1, 1, 7'h29, 32'hFFFFFFFE, 0, 0, 0, 1);
    main_tbl[5]  = vec(1, 1, 7'h38, 16'h1234, 9, 4, 0, 0, 1, 1, 7'h38, 32'h00001234, 0, 0, 0, 1);
    main_tbl[6]  = vec(1, 0, 7'h00, 16'h0000, 0, 0, 0, 0, 1, 0, 7'h38, 32'h00001234, 0, 0, 0, 1);
    main_tbl[7]  = vec(1, 1, 7'h2D, 16'h8000, 10, 4, 0, 0, 1, 0, 7'h00, 32'h0, 1, 0, 0, 0);
    main_tbl[8]  = vec(1, 1, 7'h01, 16'h0003, 11, 1, 2, 0, 0, 0, 7'h00, 32'h0, 1, 0, 0, 0);
    main_tbl[9]  = vec(1, 1, 7'h01, 16'h0003, 11, 1, 2, 0, 0, 0, 7'h00, 32'h0, 1, 0, 0, 0);
    main_tbl[10] = vec(1, 1, 7'h01, 16'h0003, 11, 1, 2, 0, 0, 0, 7'h00, 32'h0, 1, 0, 0, 0);
    main_tbl[11] = vec(1, 1, 7'h01, 16'h0003, 11, 1, 2, 1, 0, 1, 7'h2D, 32'hFFFF8000, 0, 0, 0, 1);
    main_tbl[12] = vec(1, 1, 7'h01, 16'h0003, 11, 1, 2, 0, 1, 1, 7'h01, 32'h00000003, 0, 0, 0, 1);
    main_tbl[13] = vec(1, 0, 7'h00, 16'h0000, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, 0, 0);

    // RAW on r3 via rs1, r0 never interlocks, mem write not tracked, RAW on r12 via rs2
    haz_tbl[0]  = vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, 0, 0);
    haz_tbl[1]  = vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, 0, 0);
    haz_tbl[2]  = vec(1, 1, 7'h01, 16'h0, 3, 1, 2, 0, 1, 1, 7'h01, 32'h0, 0, 0, st(0), 1);
    haz_tbl[3]  = vec(1, 1, 7'h01, 16'h0, 4, 3, 1, 0, !ILK, !ILK, 7'h01, 32'h0, 0, 0, st(1), !ILK);
    haz_tbl[4]  = vec(1, 1, 7'h01, 16'h0, 4, 3, 1, 0, !ILK, !ILK, 7'h01, 32'h0, 0, 0, st(2), !ILK);
    haz_tbl[5]  = vec(1, 1, 7'h01, 16'h0, 4, 3, 1, 0, 1, 1, 7'h01, 32'h0, 0, 0, st(2), 1);
    haz_tbl[6]  = vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, st(2), 0);
    haz_tbl[7]  = vec(1, 1, 7'h01, 16'h0, 0, 1, 2, 0, 1, 1, 7'h01, 32'h0, 0, 0, st(2), 1);
    haz_tbl[8]  = vec(1, 1, 7'h01, 16'h0, 10, 0, 0, 0, 1, 1, 7'h01, 32'h0, 0, 0, st(2), 1);
    haz_tbl[9]  = vec(1, 1, 7'h0C, 16'h4, 11, 1, 2, 0, 1, 1, 7'h0C, 32'h4, 0, 0, st(2), 1);
    haz_tbl[10] = vec(1, 1, 7'h01, 16'h0, 12, 11, 0, 0, 1, 1, 7'h01, 32'h0, 0, 0, st(2), 1);
    haz_tbl[11] = vec(1, 1, 7'h01, 16'h7, 13, 1, 12, 0, !ILK, !ILK, 7'h01, 32'h7, 0, 0, st(3), !ILK);
    haz_tbl[12] = vec(1, 1, 7'h01, 16'h7, 13, 1, 12, 0, !ILK, !ILK, 7'h01, 32'h7, 0, 0, st(4), !ILK);
    haz_tbl[13] = vec(1, 1, 7'h01, 16'h7, 13, 1, 12, 0, 1, 1, 7'h01, 32'h7, 0, 0, st(4), 1);
    haz_tbl[14] = vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, st(4), 0);

    for (int i = 0; i < 14; i++) run_vec(main_tbl[i], $sformatf("main%0d", i));

    // Timeout: TO request cycles with no ack, one mem_err pulse, nothing issued
    run_vec(vec(1, 1, 7'h2D, 16'h0010, 12, 0, 0, 0, 1, 0, 7'h00, 32'h0, 1, 0, 0, 0), "to_acc");
    idle_v = vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 1, 0, 0, 0);
    for (int i = 1; i < TO; i++) run_vec(idle_v, $sformatf("to_wait%0d", i));
    run_vec(vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 0, 1, 0, 0), "to_err");
    run_vec(vec(1, 1, 7'h01, 16'h0005, 13, 1, 2, 0, 1, 1, 7'h01, 32'h5, 0, 0, 0, 1), "to_after");

    // Reset held 3 cycles in MEM_WAIT: everything clears, no late mem_err
    run_vec(vec(1, 1, 7'h2D, 16'h0020, 14, 0, 0, 0, 1, 0, 7'h00, 32'h0, 1, 0, 0, 0), "rst_acc");
    run_vec(vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 1, 0, 0, 0), "rst_wait");
    for (int i = 0; i < 3; i++)
      run_vec(vec(0, 0, 7'h00, 16'h0, 0, 0, 0, 0, 0, 0, 7'h00, 32'h0, 0, 0, 0, 1),
              $sformatf("rst_hold%0d", i));
    run_vec(vec(1, 1, 7'h01, 16'h7FFF, 20, 1, 2, 0, 1, 1, 7'h01, 32'h7FFF, 0, 0, 0, 1), "rst_rel");
    for (int i = 0; i < TO + 2; i++)
      run_vec(vec(1, 0, 7'h00, 16'h0, 0, 0, 0, 0, 1, 0, 7'h00, 32'h0, 0, 0, 0, 0),
              $sformatf("rst_quiet%0d", i));

    for (int i = 0; i < 15; i++) run_vec(haz_tbl[i], $sformatf("haz%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
